// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through 00,01,10,11 and checks its output against the selected function.
// Optional build macro GATE_EXER_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func,
  input  logic       y_dut,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_cnt,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [2:0] ERR_MAX = 3'd4;

`ifdef GATE_EXER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t     state;
  logic [2:0] func_q;
  logic [1:0] vec;
  logic [3:0] cnt;

  logic       settle_hit;
  logic       mismatch;
  logic       last_vec;
  logic       func_legal;
  logic [3:0] mask_next;

  function automatic logic gate_fn(input logic [2:0] f, input logic x, input logic y);
    logic r;
    case (f)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // a/b are registered copies of vec, so the compare sees exactly the vector being driven
  assign settle_hit = (cnt == SETTLE);
  assign mismatch   = (y_dut != gate_fn(func_q, a, b));
  assign mask_next  = fail_mask | (mismatch ? (4'b0001 << vec) : 4'b0000);
  assign last_vec   = (vec == 2'd3) || (STOP_ON_FAIL && mismatch);
  assign func_legal = (func <= 3'd5);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      func_q    <= 3'd0;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_cnt   <= 3'd0;
      illegal   <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (func_legal) begin
              func_q    <= func;
              fail_mask <= 4'd0;
              err_cnt   <= 3'd0;
              pass      <= 1'b0;
              vec       <= 2'd0;
              cnt       <= 4'd0;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              illegal <= 1'b1;
            end
          end
        end

        RUN: begin
          if (settle_hit) begin
            fail_mask <= mask_next;
            if (mismatch && (err_cnt != ERR_MAX)) begin
              err_cnt <= err_cnt + 3'd1;
            end
            if (last_vec) begin
              // pass uses mask_next so the final vector's result is included
              pass  <= (mask_next == 4'd0);
              done  <= 1'b1;
              busy  <= 1'b0;
              a     <= 1'b0;
              b     <= 1'b0;
              state <= DONE;
            end else begin
              vec    <= vec + 2'd1;
              cnt    <= 4'd0;
              {a, b} <= vec + 2'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          a     <= 1'b0;
          b     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: SETTLE_CYCLES=2 main instance plus a SETTLE_CYCLES=0 instance.
// Expectations follow GATE_EXER_STOP_ON_FAIL_EN when the macro is defined.
module tb_gate_exerciser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] func;
  logic       y_dut;
  logic       a, b, busy, done, pass, illegal;
  logic [3:0] fail_mask;
  logic [2:0] err_cnt;

  logic       start0;
  logic [2:0] func0;
  logic       y0;
  logic       a0, b0, busy0, done0, pass0, illegal0;
  logic [3:0] fail_mask0;
  logic [2:0] err_cnt0;

  logic [2:0] gate_sel;
  logic [1:0] gate_mode;

  int vectors;
  int miscompares;

  gate_exerciser #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .y_dut(y_dut),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_cnt(err_cnt), .illegal(illegal)
  );

  gate_exerciser #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .func(func0), .y_dut(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fail_mask0), .err_cnt(err_cnt0), .illegal(illegal0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate stand-in: mode 0 correct gate, 1 stuck at 1, 2 stuck at 0
  always_comb begin
    y_dut = 1'b0;
    if (gate_mode == 2'd1) y_dut = 1'b1;
    else if (gate_mode == 2'd0) begin
      case (gate_sel)
        3'd0:    y_dut = a & b;
        3'd1:    y_dut = a | b;
        3'd2:    y_dut = ~(a & b);
        3'd3:    y_dut = ~(a | b);
        3'd4:    y_dut = a ^ b;
        3'd5:    y_dut = ~(a ^ b);
        default: y_dut = 1'b0;
      endcase
    end
  end

  assign y0 = a0 ^ b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One start pulse; func switches to fn_mid after the first busy cycle. Ends on the first non-busy negedge.
  task automatic applyStimulus(input logic [2:0] fn, input logic [2:0] fn_mid,
                               output int nbusy, output logic saw_done);
    @(negedge clk);
    func  = fn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    func  = fn_mid;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      @(negedge clk);
    end
    saw_done = done;
  endtask

  int         nb, nb2, gap;
  logic       dn, dn2, ps2;
  logic [7:0] ab_seq;
  logic [3:0] exp_mask;
  logic [2:0] exp_err;
  int         exp_busy;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    func        = 3'd0;
    start0      = 1'b0;
    func0       = 3'd0;
    gate_sel    = 3'd0;
    gate_mode   = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_flags", {26'd0, a, b, busy, done, pass, illegal}, 32'd0);
    checkOutput("reset_mask", {28'd0, fail_mask}, 32'd0);
    checkOutput("reset_err", {29'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // AND with a correct AND gate
    gate_sel = 3'd0; gate_mode = 2'd0;
    applyStimulus(3'd0, 3'd0, nb, dn);
    checkOutput("and_busy", nb, 12);
    checkOutput("and_done", {31'd0, dn}, 1);
    checkOutput("and_pass", {31'd0, pass}, 1);
    checkOutput("and_mask", {28'd0, fail_mask}, 0);
    checkOutput("and_err", {29'd0, err_cnt}, 0);
    @(negedge clk);
    checkOutput("and_done_drop", {31'd0, done}, 0);

    // AND with gate stuck at 1: 00, 01, 10 mismatch
    gate_mode = 2'd1;
`ifdef GATE_EXER_STOP_ON_FAIL_EN
    exp_busy = 3;  exp_mask = 4'b0001; exp_err = 3'd1;
`else
    exp_busy = 12; exp_mask = 4'b0111; exp_err = 3'd3;
`endif
    applyStimulus(3'd0, 3'd0, nb, dn);
    checkOutput("stuck1_busy", nb, exp_busy);
    checkOutput("stuck1_done", {31'd0, dn}, 1);
    checkOutput("stuck1_pass", {31'd0, pass}, 0);
    checkOutput("stuck1_mask", {28'd0, fail_mask}, {28'd0, exp_mask});
    checkOutput("stuck1_err", {29'd0, err_cnt}, {29'd0, exp_err});

    // Illegal func rejected, results held
    @(negedge clk);
    func  = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("illegal_pulse", {31'd0, illegal}, 1);
    checkOutput("illegal_busy", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("illegal_drop", {31'd0, illegal}, 0);
    checkOutput("illegal_busy2", {31'd0, busy}, 0);
    checkOutput("illegal_pass_held", {31'd0, pass}, 0);
    checkOutput("illegal_mask_held", {28'd0, fail_mask}, {28'd0, exp_mask});

    // XNOR with gate stuck at 0: 00 and 11 mismatch
    gate_sel = 3'd5; gate_mode = 2'd2;
`ifdef GATE_EXER_STOP_ON_FAIL_EN
    exp_busy = 3;  exp_mask = 4'b0001; exp_err = 3'd1;
`else
    exp_busy = 12; exp_mask = 4'b1001; exp_err = 3'd2;
`endif
    applyStimulus(3'd5, 3'd5, nb, dn);
    checkOutput("xnor0_busy", nb, exp_busy);
    checkOutput("xnor0_mask", {28'd0, fail_mask}, {28'd0, exp_mask});
    checkOutput("xnor0_err", {29'd0, err_cnt}, {29'd0, exp_err});

    // NOR with gate stuck at 1: 01, 10, 11 mismatch
    gate_sel = 3'd3; gate_mode = 2'd1;
`ifdef GATE_EXER_STOP_ON_FAIL_EN
    exp_busy = 6;  exp_mask = 4'b0010; exp_err = 3'd1;
`else
    exp_busy = 12; exp_mask = 4'b1110; exp_err = 3'd3;
`endif
    applyStimulus(3'd3, 3'd3, nb, dn);
    checkOutput("nor1_busy", nb, exp_busy);
    checkOutput("nor1_mask", {28'd0, fail_mask}, {28'd0, exp_mask});
    checkOutput("nor1_err", {29'd0, err_cnt}, {29'd0, exp_err});

    // NAND with a correct gate
    gate_sel = 3'd2; gate_mode = 2'd0;
    applyStimulus(3'd2, 3'd2, nb, dn);
    checkOutput("nand_busy", nb, 12);
    checkOutput("nand_pass", {31'd0, pass}, 1);
    checkOutput("nand_mask", {28'd0, fail_mask}, 0);

    // OR gate; func changed to AND mid-run must be ignored
    gate_sel = 3'd1; gate_mode = 2'd0;
    applyStimulus(3'd1, 3'd0, nb, dn);
    checkOutput("midfunc_busy", nb, 12);
    checkOutput("midfunc_pass", {31'd0, pass}, 1);
    checkOutput("midfunc_mask", {28'd0, fail_mask}, 0);

    // Reset on the 5th busy cycle aborts without done
    gate_sel = 3'd0; gate_mode = 2'd0;
    @(negedge clk);
    func  = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_flags", {26'd0, a, b, busy, done, pass, illegal}, 0);
    checkOutput("abort_mask_err", {25'd0, fail_mask, err_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_done", {30'd0, busy, done}, 0);
    applyStimulus(3'd0, 3'd0, nb, dn);
    checkOutput("after_abort_busy", nb, 12);
    checkOutput("after_abort_pass", {31'd0, pass}, 1);

    // start held high: back-to-back OR runs, DONE plus one IDLE cycle between them
    gate_sel = 3'd1; gate_mode = 2'd0;
    @(negedge clk);
    func  = 3'd1;
    start = 1'b1;
    @(negedge clk);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    dn  = done;
    ps2 = pass;
    gap = 1;
    @(negedge clk);
    while (busy !== 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    start = 1'b0;
    nb2 = 0;
    while (busy === 1'b1 && nb2 < 200) begin
      nb2++;
      @(negedge clk);
    end
    dn2 = done;
    checkOutput("b2b_busy1", nb, 12);
    checkOutput("b2b_done1", {30'd0, dn, ps2}, 3);
    checkOutput("b2b_gap", gap, 2);
    checkOutput("b2b_busy2", nb2, 12);
    checkOutput("b2b_done2", {30'd0, dn2, pass}, 3);
    repeat (2) @(negedge clk);
    checkOutput("b2b_stop", {31'd0, busy}, 0);

    // SETTLE_CYCLES=0 XOR run: one cycle per vector
    @(negedge clk);
    func0  = 3'd4;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    nb     = 0;
    ab_seq = 8'd0;
    while (busy0 === 1'b1 && nb < 200) begin
      nb++;
      ab_seq = {ab_seq[5:0], a0, b0};
      @(negedge clk);
    end
    checkOutput("xor_busy", nb, 4);
    checkOutput("xor_ab_seq", {24'd0, ab_seq}, 32'h1B);
    checkOutput("xor_done_pass", {30'd0, done0, pass0}, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
